// File: rtl/rf_pkg.sv
// Shared sizing constants for the general-purpose register file.
package rf_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] RF_ZERO_IDX = '0;

endpackage

// File: rtl/rf_write_decoder.sv
// One-hot write-enable decoder; the zero register can never be selected.
module rf_write_decoder
    import rf_pkg::*;
(
    input  logic [ADDR_W-1:0] ad_i,
    input  logic              we_i,
    output logic [NREGS-1:0]  wen_o
);

    always_comb begin
        wen_o = '0;
        if (we_i) begin
            wen_o[ad_i] = 1'b1;
        end
        wen_o[RF_ZERO_IDX] = 1'b0;
    end

endmodule

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
module register_file
    import rf_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] ad,
    input  logic [DATA_W-1:0] di,
    input  logic              we,
    output logic [DATA_W-1:0] do1,
    output logic [DATA_W-1:0] do2
);

    logic [NREGS-1:0]  wen;
    logic [DATA_W-1:0] regs_q [NREGS];

    rf_write_decoder u_wdec (
        .ad_i  (ad),
        .we_i  (we),
        .wen_o (wen)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wen[i]) begin
                    regs_q[i] <= di;
                end
            end
        end
    end

    // Address 0 is masked on read as well, so it is zero even before the first reset.
    always_comb begin
        do1 = (a1 == RF_ZERO_IDX) ? '0 : regs_q[a1];
        do2 = (a2 == RF_ZERO_IDX) ? '0 : regs_q[a2];
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: behavioural model plus directed vectors.
module tb_register_file;

    logic        CLK;
    logic        reset;
    logic [4:0]  a1, a2, ad;
    logic [31:0] di;
    logic        we;
    logic [31:0] do1, do2;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic [31:0] model [32];

    register_file dut (
        .CLK   (CLK),
        .reset (reset),
        .a1    (a1),
        .a2    (a2),
        .ad    (ad),
        .di    (di),
        .we    (we),
        .do1   (do1),
        .do2   (do2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model: reset clears everything, a write stores di unless it targets register 0.
    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we === 1'b1 && ad != 5'd0) begin
            model[ad] = di;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            check("do1_model", do1, exp_rd(a1));
            check("do2_model", do2, exp_rd(a2));
        end
    end

    task automatic cycle(input logic w, input logic [4:0] adr, input logic [31:0] d);
        we = w;
        ad = adr;
        di = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        reset = 1'b0;
        we = 1'b0; ad = '0; di = '0; a1 = '0; a2 = '0;

        // 1: reset held, then released; all addresses read zero
        #6;
        reset = 1'b1;
        #1;
        mon_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            #1;
            check("post_reset_do1", do1, 32'd0);
            check("post_reset_do2", do2, 32'd0);
        end

        // 2: write 10*k to every register, then read back in pairs
        @(posedge CLK); #1;
        for (int k = 0; k < 32; k++) cycle(1'b1, 5'(k), 32'(10 * k));
        we = 1'b0;
        for (int k = 0; k < 32; k += 2) begin
            a1 = 5'(k);
            a2 = 5'(k + 1);
            #1;
            check("fill_do1", do1, 32'(10 * k));
            check("fill_do2", do2, 32'(10 * (k + 1)));
        end
        a1 = 5'd31; a2 = 5'd1; #1;
        check("reg31_literal", do1, 32'd310);
        check("reg1_literal", do2, 32'd10);
        a1 = 5'd0; #1;
        check("reg0_literal", do1, 32'd0);

        // 3: asynchronous reset between clock edges
        a1 = 5'd20; a2 = 5'd21;
        @(posedge CLK); #1;
        check("pre_async_do1", do1, 32'd200);
        reset = 1'b0;
        #1;
        check("async_do1", do1, 32'd0);
        check("async_do2", do2, 32'd0);
        we = 1'b1; ad = 5'd3; di = 32'h1234_5678;
        #20;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'((i + 7) % 32);
            #1;
            check("held_reset_do1", do1, 32'd0);
            check("held_reset_do2", do2, 32'd0);
        end
        we = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK); #1;

        // 4: write enable gating
        cycle(1'b1, 5'd5, 32'd55);
        a1 = 5'd5;
        cycle(1'b0, 5'd5, 32'hDEAD_BEEF);
        check("we0_keeps", do1, 32'd55);
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF);
        check("we1_writes", do1, 32'hDEAD_BEEF);

        // 5: writes to register 0 are discarded
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF);
        a1 = 5'd0; a2 = 5'd0; #1;
        check("zero_do1", do1, 32'd0);
        check("zero_do2", do2, 32'd0);

        // 6: same-address read/write has no bypass
        cycle(1'b1, 5'd7, 32'd77);
        we = 1'b1; ad = 5'd7; di = 32'd123; a1 = 5'd7; a2 = 5'd7;
        #2;
        check("nobypass_old_do1", do1, 32'd77);
        check("nobypass_old_do2", do2, 32'd77);
        @(posedge CLK); #1;
        check("nobypass_new_do1", do1, 32'd123);
        check("nobypass_new_do2", do2, 32'd123);

        // reset asserted across a write edge wins
        a1 = 5'd9; a2 = 5'd5;
        we = 1'b1; ad = 5'd9; di = 32'd999;
        #2;
        reset = 1'b0;
        @(posedge CLK); #1;
        check("reset_wins_do1", do1, 32'd0);
        check("reset_wins_do2", do2, 32'd0);
        we = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK); #1;
        check("after_reset_do1", do1, 32'd0);

        @(negedge CLK);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the processor datapath.
- Two combinational read ports (do1/do2) feed the ALU operand paths; one synchronous write port (ad/di/we) is driven by writeback.
- Asynchronous active-low reset clears every register to zero.

Parameters:
- DATA_W, 32, width of each register and of di/do1/do2.
- ADDR_W, 5, width of a1/a2/ad.
- NREGS, 32 (2**ADDR_W), number of registers.

Ports:
- CLK  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all registers immediately.
- a1  input  ADDR_W  read address, port 1.
- a2  input  ADDR_W  read address, port 2.
- ad  input  ADDR_W  write address.
- di  input  DATA_W  write data.
- we  input  1  write enable, active-high.
- do1  output  DATA_W  contents of register a1.
- do2  output  DATA_W  contents of register a2.

Behaviour:
- Storage is regs[0..NREGS-1], each DATA_W bits.
- Reset:
  - When reset=0, all regs go to 0 asynchronously, without waiting for a clock edge.
  - While reset is held low, all regs stay 0 and writes are ignored.
  - Consequently do1=do2=0 for any address.
- Reset release: the first write can occur at the first rising CLK edge with reset=1 and we=1.
- Write:
  - On rising CLK with reset=1 and we=1: regs[ad] <= di.
  - With we=0, no register changes.
- Register 0 is hardwired to zero:
  - Writes to ad=0 are discarded.
  - Reads of address 0 always return 0.
- Read:
  - Purely combinational, zero latency: do1 = regs[a1], do2 = regs[a2].
  - Outputs follow address changes within the same cycle.
  - Both ports are independent; a1=a2 is legal and both return the same value.
- Write/read same address in the same cycle: no bypass.
  - Before the edge, the read port shows the old value.
  - It shows di after the rising edge.
- Reset asserted mid-write: reset wins, and the register is 0 after the edge.
- All addresses are in range (5 bits cover 32 registers); no out-of-range handling is required.
- No X on outputs after the first reset.

Decomposition:
- Shared package rf_pkg holds DATA_W, ADDR_W, NREGS and the zero-register index constant RF_ZERO_IDX=0.
- One sub-module, rf_write_decoder:
  - Inputs ad and we.
  - Outputs a one-hot NREGS-bit write-enable vector, with bit 0 forced to 0.
  - The top level instantiates it and builds the register array and the two read muxes.

Test Plan:
1. Hold reset=0 for 5 ns, then release → every a1/a2 pair from 0..31 reads 0.
2. Release reset; over 32 consecutive cycles set ad=k, di=10*k, we=1 for k=0..31; then read pairs (a1=k, a2=k+1, k even) → reg[0]=0, reg[1]=10, reg[2]=20 … reg[31]=310.
3. After scenario 2, drive reset=0 with no clock edge → outputs go to 0 immediately; after 20 ns every pair reads 0.
4. Write ad=5, di=32'hDEADBEEF with we=0 → a1=5 still reads its previous value; repeat with we=1 → reads 32'hDEADBEEF after the rising edge.
5. Write ad=0, di=32'hFFFFFFFF, we=1 → a1=0 and a2=0 both read 0.
6. Set a1=a2=ad=7, di=123, we=1 → do1/do2 show the old reg[7] before the edge and 123 after it.
